// File: rtl/ssd_scan_if.sv
// Producer-side handshake bundle for ssd_scan_ctrl.
// SSD_SCAN_DP_EN adds per-digit decimal-point bits alongside the value.
interface ssd_scan_if #(
  parameter int NDIGITS = 4
);
  logic [4*NDIGITS-1:0] value;
  logic                 load;
  logic                 ready;
`ifdef SSD_SCAN_DP_EN
  logic [NDIGITS-1:0]   dp_in;

  modport master (output value, load, dp_in, input ready);
  modport slave  (input value, load, dp_in, output ready);
`else
  modport master (output value, load, input ready);
  modport slave  (input value, load, output ready);
`endif
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed common-anode seven-segment scan controller with shadow/active value swap.
// Optional SSD_SCAN_DP_EN adds decimal-point input (via bus.dp_in) and dp_n output.
module ssd_scan_ctrl #(
  parameter int NDIGITS = 4,
  parameter int DIV     = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               lzs,
  ssd_scan_if.slave          bus,
  output logic [6:0]         seg_n,
  output logic [NDIGITS-1:0] an_n
`ifdef SSD_SCAN_DP_EN
  , output logic             dp_n
`endif
);
  localparam int IW = $clog2(NDIGITS);
  localparam int CW = $clog2(DIV);

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;  4'h9: decode = 7'h67;
      4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;  default: decode = 7'h71;
    endcase
  endfunction

  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [4*NDIGITS-1:0] active, shadow;
  logic                 full;
  logic                 tick, last, wrap;
  logic [3:0]           nib;
  logic                 upper_nz, sup;
`ifdef SSD_SCAN_DP_EN
  logic [NDIGITS-1:0]   dp_act, dp_shd;
  logic                 dp_bit;
`endif

  assign tick      = en && (cnt == CW'(DIV-1));
  assign last      = (idx == IW'(NDIGITS-1));
  assign wrap      = tick && last;
  assign bus.ready = ~full;

  // Current nibble plus "this digit and everything above is zero" for suppression.
  always_comb begin
    nib      = '0;
    upper_nz = 1'b0;
`ifdef SSD_SCAN_DP_EN
    dp_bit   = 1'b0;
`endif
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib = active[4*i +: 4];
`ifdef SSD_SCAN_DP_EN
        dp_bit = dp_act[i];
`endif
      end
      if ((IW'(i) >= idx) && (active[4*i +: 4] != 4'h0)) upper_nz = 1'b1;
    end
    sup = lzs && (idx != '0) && !upper_nz;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= '0;
      active <= '0;
      shadow <= '0;
      full   <= 1'b0;
`ifdef SSD_SCAN_DP_EN
      dp_act <= '0;
      dp_shd <= '0;
`endif
    end else begin
      if (!en) begin
        cnt <= '0;
        idx <= '0;
      end else if (tick) begin
        cnt <= '0;
        idx <= last ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
      // Swap only at frame end so a frame never mixes old and new digits.
      if (wrap && full) begin
        active <= shadow;
        full   <= 1'b0;
`ifdef SSD_SCAN_DP_EN
        dp_act <= dp_shd;
`endif
      end else if (bus.load && !full) begin
        shadow <= bus.value;
        full   <= 1'b1;
`ifdef SSD_SCAN_DP_EN
        dp_shd <= bus.dp_in;
`endif
      end
    end
  end

  // Tick cycle blanks the anodes so the old segments never ghost onto the next digit.
  always_ff @(posedge clk) begin
    if (!rst_n || !en || tick || sup) begin
      seg_n <= 7'h7F;
      an_n  <= '1;
`ifdef SSD_SCAN_DP_EN
      dp_n  <= 1'b1;
`endif
    end else begin
      seg_n <= ~decode(nib);
      an_n  <= ~(NDIGITS'(1) << idx);
`ifdef SSD_SCAN_DP_EN
      dp_n  <= ~dp_bit;
`endif
    end
  end
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: vector table, directed corner sequences, and random run
// checked against a frame-phase model of the display.
module tb_ssd_scan_ctrl;
  localparam int N   = 4;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, en = 1'b0, lzs = 1'b0, load = 1'b0;
  logic [15:0] value = '0;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
`ifdef SSD_SCAN_DP_EN
  logic [3:0]  dp_in = '0;
  logic        dp_n;
`endif

  ssd_scan_if #(.NDIGITS(N)) bus();
  assign bus.value = value;
  assign bus.load  = load;
`ifdef SSD_SCAN_DP_EN
  assign bus.dp_in = dp_in;
`endif

  ssd_scan_ctrl #(.NDIGITS(N), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .lzs(lzs), .bus(bus),
    .seg_n(seg_n), .an_n(an_n)
`ifdef SSD_SCAN_DP_EN
    , .dp_n(dp_n)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Model: ph = enabled-cycle position within a frame (0 .. N*DIV-1).
  logic [6:0]  dec [16];
  int          ph;
  logic [15:0] act, shd;
  logic [3:0]  dpa, dps;
  logic        full;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_rdy, e_dp;

  typedef struct {
    logic        rst_n, en, lzs, load;
    logic [15:0] value;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        rdy;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int pos, dig;
    logic tk, wr, sup;
    logic [15:0] sh;
    logic [3:0] cur_dp;
    cur_dp = '0;
`ifdef SSD_SCAN_DP_EN
    cur_dp = dp_in;
`endif
    if (!rst_n) begin
      ph = 0; act = '0; shd = '0; full = 1'b0; dpa = '0; dps = '0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      pos = ph % DIV;
      dig = ph / DIV;
      tk  = en && (pos == DIV-1);
      wr  = tk && (dig == N-1);
      sh  = act >> (4*dig);
      sup = lzs && (dig > 0) && (sh == 16'h0);
      if (!en || tk || sup) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an = ~(4'b0001 << dig); e_seg = ~dec[sh[3:0]]; e_dp = ~dpa[dig];
      end
      ph = en ? (ph + 1) % (N*DIV) : 0;
      if (wr && full) begin
        act = shd; dpa = dps; full = 1'b0;
      end else if (load && !full) begin
        shd = value; dps = cur_dp; full = 1'b1;
      end
    end
    e_rdy = !full;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("an_n", an_n, e_an);
    chk("seg_n", seg_n, e_seg);
    chk("ready", bus.ready, e_rdy);
`ifdef SSD_SCAN_DP_EN
    chk("dp_n", dp_n, e_dp);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0; load = 1'b0; en = 1'b0; lzs = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic add(input logic r, e, l, ld, input logic [15:0] v,
                     input logic [3:0] a, input logic [6:0] s, input logic rd);
    vec_t t;
    t.rst_n = r; t.en = e; t.lzs = l; t.load = ld; t.value = v;
    t.an = a; t.seg = s; t.rdy = rd;
    vecs.push_back(t);
  endtask

  task automatic wait_ready(input string nm, output int k);
    k = 0;
    while (bus.ready !== 1'b1 && k < 64) begin step(); k++; end
    if (k >= 64) chk({nm, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    logic [3:0] anv [4];
    logic [6:0] sgv [4];
    int k, n_bad, n_good;
    logic [15:0] msk;

    dec = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    anv = '{4'hE, 4'hD, 4'hB, 4'h7};
    sgv = '{7'h19, 7'h30, 7'h24, 7'h79};

    // Reset, load 1234, first frame shows zeros, second frame shows 1234.
    repeat (3) add(0, 0, 0, 0, 16'h0, 4'hF, 7'h7F, 1);
    add(1, 1, 0, 1, 16'h1234, 4'hE, 7'h40, 0);
    repeat (2) add(1, 1, 0, 0, 16'h1234, 4'hE, 7'h40, 0);
    add(1, 1, 0, 0, 16'h1234, 4'hF, 7'h7F, 0);
    for (int d = 1; d < 4; d++) begin
      repeat (3) add(1, 1, 0, 0, 16'h1234, anv[d], 7'h40, 0);
      add(1, 1, 0, 0, 16'h1234, 4'hF, 7'h7F, (d == 3));
    end
    for (int d = 0; d < 4; d++) begin
      repeat (3) add(1, 1, 0, 0, 16'h1234, anv[d], sgv[d], 1);
      add(1, 1, 0, 0, 16'h1234, 4'hF, 7'h7F, 1);
    end
    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; en = vecs[i].en; lzs = vecs[i].lzs;
      load = vecs[i].load; value = vecs[i].value;
      step();
      chk("vec_an", an_n, vecs[i].an);
      chk("vec_seg", seg_n, vecs[i].seg);
      chk("vec_rdy", bus.ready, vecs[i].rdy);
    end

    // Handshake: second value waits for the frame swap, then follows a frame later.
    do_reset(); en = 1'b1;
    value = 16'hAAAA; load = 1'b1; step();
    chk("hs_acc1", bus.ready, 0);
    value = 16'h5555;
    wait_ready("hs_wait", k);
    chk("hs_wait_cycles", k, 15);
    step(); load = 1'b0;
    chk("hs_acc2", bus.ready, 0);
    chk("hs_d0_an", an_n, 4'hE);
    chk("hs_d0_A", seg_n, 7'h08);
    repeat (15) step();
    step();
    chk("hs_d0_5", seg_n, 7'h12);

    // Leading-zero suppression.
    do_reset(); en = 1'b1; lzs = 1'b1;
    value = 16'h0070; load = 1'b1; step(); load = 1'b0;
    n_bad = 0; n_good = 0;
    repeat (48) begin
      step();
      if (an_n == 4'h7 || an_n == 4'hB) n_bad++;
      if (an_n == 4'hD && seg_n == 7'h78) n_good++;
      if (an_n == 4'hE && seg_n != 7'h40) n_bad++;
    end
    chk("lzs_dark", n_bad, 0);
    chk("lzs_d1_seen", (n_good > 0), 1);
    value = 16'h0000; load = 1'b1; step(); load = 1'b0;
    wait_ready("lzs0_wait", k);
    n_bad = 0;
    repeat (32) begin
      step();
      if (an_n != 4'hE && an_n != 4'hF) n_bad++;
      if (an_n == 4'hE && seg_n != 7'h40) n_bad++;
    end
    chk("lzs_zero", n_bad, 0);

    // Enable drop at idx 2, then restart from digit 0.
    lzs = 1'b0; value = 16'h1234; load = 1'b1; step(); load = 1'b0;
    k = 0;
    while (!((ph / DIV) == 2 && (ph % DIV) == 1) && k < 64) begin step(); k++; end
    if (k >= 64) chk("en_sync_timeout", 32'd1, 32'd0);
    en = 1'b0; step();
    chk("en_off_an", an_n, 4'hF);
    chk("en_off_seg", seg_n, 7'h7F);
    repeat (3) step();
    en = 1'b1; step();
    chk("en_on_an", an_n, 4'hE);

`ifdef SSD_SCAN_DP_EN
    do_reset(); en = 1'b1;
    value = 16'h1234; dp_in = 4'b0100; load = 1'b1; step(); load = 1'b0; dp_in = '0;
    wait_ready("dp_wait", k);
    n_bad = 0; n_good = 0;
    repeat (32) begin
      step();
      if (dp_n == 1'b0 && an_n != 4'hB) n_bad++;
      if (dp_n == 1'b0 && an_n == 4'hB) n_good++;
    end
    chk("dp_only_b", n_bad, 0);
    chk("dp_seen", (n_good > 0), 1);
`endif

    // Random traffic against the model.
    do_reset();
    repeat (1500) begin
      rst_n = ($urandom_range(0, 199) != 0);
      en    = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 63) == 0) lzs = ~lzs;
      load  = ($urandom_range(0, 2) == 0);
      msk = '0;
      for (int j = 0; j < 4; j++) if ($urandom_range(0, 1) == 1) msk[4*j +: 4] = 4'hF;
      value = 16'($urandom) & msk;
`ifdef SSD_SCAN_DP_EN
      dp_in = 4'($urandom);
`endif
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
